gen_sched: RTL
==============

// Module: gen_sched
// PURPOSE
//  Generation scheduler between main_ctrl and the life board engine.
//  Turns command pulses (clear, rand, one_gen, speed) and run_mode into one serialized op stream to the engine.
//  Runs a speed-scaled step timer and a req/ack/done handshake.
//  Keeps the generation counter and current speed level for the display overlay.
// PARAMETERS
//  TICK_DIV      1_000_000  clk cycles per base tick (sim benches use 4)
//  SPEED_LEVELS  8          number of speed levels; level 0 is slowest
//  SPEED_RESET   3          speed_level after reset
//  GEN_W         16         width of gen_count
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  run_mode     in   1      1 = RUN, 0 = EDIT
//  clear_cmd    in   1      1-cycle pulse: clear board
//  rand_cmd     in   1      1-cycle pulse: randomize board
//  one_gen      in   1      1-cycle pulse: single step (honoured in EDIT only)
//  inc_speed    in   1      1-cycle pulse: raise speed level
//  dec_speed    in   1      1-cycle pulse: lower speed level
//  eng_req      out  1      op request valid; held until eng_ack
//  eng_op       out  2      ENG_OP_T; stable while eng_req=1
//  eng_ack      in   1      engine accepts op (sampled only when eng_req=1)
//  eng_done     in   1      1-cycle pulse: accepted op finished
//  speed_level  out  $clog2(SPEED_LEVELS)  current level
//  gen_count    out  GEN_W  generations since last clear/rand
//  step_overrun out  1      1-cycle pulse: timer step dropped (step already pending)
//  sched_busy   out  1      op in flight or any op pending
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except speed_level=SPEED_RESET.
//  - FSM=IDLE, pending flags clear, prescaler and period counters 0.
//  - Reset mid-op: eng_req low on the next cycle; a late eng_done is ignored in IDLE.
//  Timer:
//  - Prescaler wraps every TICK_DIV cycles, giving a base tick.
//  - Step period = 2^(SPEED_LEVELS-1-speed_level) base ticks.
//  - Timer runs only while run_mode=1; on expiry it sets step_pend.
//  - Rising run_mode, or any speed change, restarts both counters, so the first step comes one full period later.
//  Speed:
//  - inc saturates at SPEED_LEVELS-1; dec saturates at 0.
//  - inc and dec in the same cycle: no change.
//  Pending flags (clear_pend, rand_pend, step_pend), one of each:
//  - one_gen sets step_pend only when run_mode=0.
//  - A step request while step_pend=1 is dropped. A dropped timer step also pulses step_overrun.
//  - clear_cmd sets clear_pend and clears rand_pend and step_pend.
//  - rand_cmd sets rand_pend and clears step_pend.
//  - clear_cmd and rand_cmd in the same cycle: clear wins, rand is discarded.
//  - run_mode falling clears step_pend; an in-flight step still completes.
//  FSM (IDLE, REQ, WAIT):
//  - IDLE: if any flag is pending, pick by priority CLEAR > RAND > STEP, drive eng_op, assert eng_req, go to REQ, and clear that flag.
//  - Latency: command pulse at cycle t -> eng_req=1 at t+1 when IDLE.
//  - REQ: hold eng_req and eng_op until eng_ack. On ack, drop eng_req next cycle and go to WAIT. If ack and done arrive together, go straight to IDLE.
//  - WAIT: on eng_done, go to IDLE. The next op may issue on the cycle after.
//  - New pulses arriving in REQ or WAIT only update the pending flags.
//  gen_count:
//  - +1 on eng_done of STEP; wraps modulo 2^GEN_W.
//  - Set to 0 on eng_done of CLEAR or RAND.
//  sched_busy = (state != IDLE) | any pending flag.
// STRUCTURE
//  gol_pkg holds:
//  - typedef enum logic[1:0] ENG_OP_T {OP_STEP, OP_CLEAR, OP_RAND}.
//  - typedef enum SCHED_STATE_T {S_IDLE, S_REQ, S_WAIT}.
//  Sub-module tick_prescaler(clk, rst, clr, tick): divide-by-TICK_DIV, synchronous clear. Instantiate once.
//  Period counter, pending flags and FSM stay in gen_sched; all state in DQFF-style flops.
// TESTING (TICK_DIV=4, SPEED_LEVELS=8, engine model: ack 2 cycles after req, done 3 cycles after ack)
//  1. Reset, EDIT mode, one_gen pulse at t:
//     - eng_req=1 with OP_STEP at t+1, held until ack.
//     - gen_count 0 -> 1 at done.
//     - sched_busy returns to 0.
//  2. RUN at speed_level=7 (period 1 tick):
//     - steps issue every 4+ cycles, as allowed by the handshake.
//     - After 10 done pulses, gen_count=10.
//     - Stretch the engine done to 20 cycles: step_overrun pulses and no more than one step is pending.
//  3. Speed limits:
//     - 5x inc_speed from 3 -> speed_level=7.
//     - 9x dec_speed -> 0.
//     - inc and dec in the same cycle -> unchanged.
//     - At level 0, first step comes 128*4=512 cycles after run_mode rises.
//  4. clear_cmd and rand_cmd in the same cycle while a step is in flight:
//     - the step completes, then exactly one OP_CLEAR follows and no OP_RAND.
//     - gen_count=0 after that done.
//  5. Engine holds eng_ack=0 for 50 cycles:
//     - eng_op and eng_req stay stable throughout.
//     - rand_cmd during the hold issues as the next op after done.
//  6. Assert rst while in WAIT:
//     - next cycle eng_req=0, speed_level=3, gen_count=0.
//     - a stray eng_done afterwards does not change gen_count.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types for the generation scheduler: engine opcodes, FSM states and pending-flag bundle.
package gol_pkg;

  typedef enum logic [1:0] {
    OP_STEP  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_RAND  = 2'd2
  } eng_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic clr;
    logic rnd;
    logic step;
  } pend_t;

  // Step period minus one, in base ticks: 2^(levels-1-lvl) - 1.
  function automatic int unsigned period_ticks_m1(input int unsigned lvl,
                                                  input int unsigned levels);
    return (32'd1 << (levels - 32'd1 - lvl)) - 32'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-TICK_DIV base tick generator with synchronous clear; tick is a registered 1-cycle pulse.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/gen_sched.sv
// Generation scheduler: serializes clear/rand/step requests into a req/ack/done op stream
// to the life engine, runs the speed-scaled step timer and keeps gen_count / speed_level.
module gen_sched
  import gol_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1_000_000,
  parameter int unsigned SPEED_LEVELS = 8,
  parameter int unsigned SPEED_RESET  = 3,
  parameter int unsigned GEN_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run_mode,
  input  logic                            clear_cmd,
  input  logic                            rand_cmd,
  input  logic                            one_gen,
  input  logic                            inc_speed,
  input  logic                            dec_speed,
  output logic                            eng_req,
  output eng_op_t                         eng_op,
  input  logic                            eng_ack,
  input  logic                            eng_done,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed_level,
  output logic [GEN_W-1:0]                gen_count,
  output logic                            step_overrun,
  output logic                            sched_busy
);

  localparam int unsigned LVL_W = $clog2(SPEED_LEVELS);
  localparam int unsigned PER_W = (SPEED_LEVELS > 2) ? SPEED_LEVELS - 1 : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(SPEED_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(SPEED_RESET);

  sched_state_t     state_q, state_d;
  eng_op_t          op_q, op_d;
  logic             req_q, req_d;
  pend_t            pend_q, pend_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             run_q, run_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  logic tick;
  logic restart;
  logic expire;
  logic step_req;
  logic done_evt;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .tick(tick)
  );

  always_comb begin
    lvl_d    = lvl_q;
    run_d    = run_mode;
    per_d    = per_q;
    expire   = 1'b0;
    pend_d   = pend_q;
    ovr_d    = 1'b0;
    step_req = 1'b0;
    state_d  = state_q;
    req_d    = req_q;
    op_d     = op_q;
    gen_d    = gen_q;
    done_evt = 1'b0;
    busy_d   = 1'b0;

    // Speed level: saturating, simultaneous inc/dec cancels
    if (inc_speed && !dec_speed && lvl_q != LVL_MAX) begin
      lvl_d = lvl_q + LVL_W'(1);
    end else if (dec_speed && !inc_speed && lvl_q != '0) begin
      lvl_d = lvl_q - LVL_W'(1);
    end

    // Timer is held in restart outside RUN so the first step is a full period after entry
    restart = ~run_mode | (run_mode & ~run_q) | (lvl_d != lvl_q);
    if (restart) begin
      per_d = '0;
    end else if (tick) begin
      if (per_q == PER_W'(period_ticks_m1(32'(lvl_q), SPEED_LEVELS))) begin
        per_d  = '0;
        expire = 1'b1;
      end else begin
        per_d = per_q + PER_W'(1);
      end
    end

    step_req = (one_gen & ~run_mode) | expire;
    if (step_req) begin
      if (pend_q.step) begin
        ovr_d = expire;
      end else begin
        pend_d.step = 1'b1;
      end
    end
    if (clear_cmd) begin
      pend_d.clr  = 1'b1;
      pend_d.rnd  = 1'b0;
      pend_d.step = 1'b0;
    end else if (rand_cmd) begin
      pend_d.rnd  = 1'b1;
      pend_d.step = 1'b0;
    end
    if (run_q && !run_mode) begin
      pend_d.step = 1'b0;
    end

    // Handshake FSM; IDLE sees this cycle's pulses so a command issues on the next cycle
    case (state_q)
      S_IDLE: begin
        if (|pend_d) begin
          req_d   = 1'b1;
          state_d = S_REQ;
          if (pend_d.clr) begin
            op_d       = OP_CLEAR;
            pend_d.clr = 1'b0;
          end else if (pend_d.rnd) begin
            op_d       = OP_RAND;
            pend_d.rnd = 1'b0;
          end else begin
            op_d        = OP_STEP;
            pend_d.step = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (eng_ack) begin
          req_d = 1'b0;
          if (eng_done) begin
            state_d  = S_IDLE;
            done_evt = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d  = S_IDLE;
          done_evt = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (done_evt) begin
      gen_d = (op_q == OP_STEP) ? gen_q + GEN_W'(1) : '0;
    end

    busy_d = (state_d != S_IDLE) | (|pend_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_STEP;
      req_q   <= 1'b0;
      pend_q  <= '0;
      lvl_q   <= LVL_RST;
      gen_q   <= '0;
      per_q   <= '0;
      run_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      lvl_q   <= lvl_d;
      gen_q   <= gen_d;
      per_q   <= per_d;
      run_q   <= run_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign eng_req      = req_q;
  assign eng_op       = op_q;
  assign speed_level  = lvl_q;
  assign gen_count    = gen_q;
  assign step_overrun = ovr_q;
  assign sched_busy   = busy_q;

endmodule
